// File: rtl/skid_buffer.sv
// Two-entry valid/ready skid buffer with registered handshake outputs.
// Ports: clk, async_rst_n, s_valid/s_data/s_ready in, m_valid/m_data/m_ready out, level.
module skid_buffer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             async_rst_n,
  input  logic             s_valid,
  input  logic [WIDTH-1:0] s_data,
  output logic             s_ready,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready,
  output logic [1:0]       level
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             in_hs;
  logic             out_hs;

  assign in_hs  = s_valid & s_ready;
  assign out_hs = m_valid & m_ready;
  assign m_data = main_q;

  // Outputs are registered alongside the state so that neither
  // s_ready nor m_valid has a combinational path from the inputs.
  // s_ready is held low in reset; the first edge after release
  // lands in EMPTY with in_hs=0 and simply raises it.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      s_ready <= 1'b0;
      m_valid <= 1'b0;
      level   <= 2'd0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_hs) begin
            main_q  <= s_data;
            state_q <= BUSY;
            s_ready <= 1'b1;
            m_valid <= 1'b1;
            level   <= 2'd1;
          end else begin
            s_ready <= 1'b1;
            m_valid <= 1'b0;
            level   <= 2'd0;
          end
        end
        BUSY: begin
          unique case (1'b1)
            (in_hs && out_hs): begin
              main_q <= s_data;
            end
            (in_hs && !out_hs): begin
              skid_q  <= s_data;
              state_q <= FULL;
              s_ready <= 1'b0;
              level   <= 2'd2;
            end
            (!in_hs && out_hs): begin
              state_q <= EMPTY;
              m_valid <= 1'b0;
              level   <= 2'd0;
            end
            default: begin
            end
          endcase
        end
        FULL: begin
          if (out_hs) begin
            main_q  <= skid_q;
            state_q <= BUSY;
            s_ready <= 1'b1;
            level   <= 2'd1;
          end
        end
        default: begin
          state_q <= EMPTY;
          s_ready <= 1'b1;
          m_valid <= 1'b0;
          level   <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_skid_buffer.sv
// Bench for skid_buffer: directed phases plus random backpressure,
// checked against a two-deep FIFO queue model.
module tb_skid_buffer;

  localparam int W = 4;

  logic         clk;
  logic         async_rst_n;
  logic         s_valid;
  logic [W-1:0] s_data;
  logic         s_ready;
  logic         m_valid;
  logic [W-1:0] m_data;
  logic         m_ready;
  logic [1:0]   level;

  int tests;
  int fails;

  logic [W-1:0] q[$];
  logic         exp_rdy;

  skid_buffer #(.WIDTH(W)) dut (
    .clk        (clk),
    .async_rst_n(async_rst_n),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .level      (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".s_ready"}, 32'(s_ready), 32'(exp_rdy));
    chk({tag, ".m_valid"}, 32'(m_valid), 32'(q.size() != 0));
    chk({tag, ".level"}, 32'(level), 32'(q.size()));
    if (q.size() != 0)
      chk({tag, ".m_data"}, 32'(m_data), 32'(q[0]));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".s_ready"}, 32'(s_ready), 32'd0);
    chk({tag, ".m_valid"}, 32'(m_valid), 32'd0);
    chk({tag, ".level"}, 32'(level), 32'd0);
    chk({tag, ".m_data"}, 32'(m_data), 32'd0);
  endtask

  // One clock: drive, advance the FIFO model at the edge, check.
  task automatic cycle(input logic sv,
                       input logic [W-1:0] sd,
                       input logic mr,
                       input string tag,
                       output logic took);
    logic do_in;
    logic do_out;
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
    @(posedge clk);
    do_in  = sv && exp_rdy;
    do_out = (q.size() != 0) && mr;
    if (do_out) void'(q.pop_front());
    if (do_in) q.push_back(sd);
    exp_rdy = (q.size() < 2);
    took = do_in;
    @(negedge clk);
    check_model(tag);
  endtask

  initial begin
    logic t;
    int   sent;
    int   cyc;
    tests = 0;
    fails = 0;
    exp_rdy = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    async_rst_n = 1'b0;

    // Reset held across three edges.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_reset("rst_hold");
    end
    #1 async_rst_n = 1'b1;

    // First edge after release: no transfer, s_ready rises.
    cycle(1'b1, 4'hE, 1'b1, "rst_first", t);
    chk("rst_first.no_take", 32'(t), 32'd0);

    // Streaming with m_ready held high.
    for (int i = 1; i <= 15; i++)
      cycle(1'b1, W'(i), 1'b1, "stream", t);
    cycle(1'b0, '0, 1'b1, "stream_end", t);

    // Stall and skid.
    cycle(1'b1, 4'hA, 1'b0, "stall_a", t);
    cycle(1'b1, 4'hB, 1'b0, "stall_b", t);
    cycle(1'b1, 4'hC, 1'b0, "stall_hold", t);
    chk("stall_hold.level", 32'(level), 32'd2);
    chk("stall_hold.data", 32'(m_data), 32'hA);
    cycle(1'b0, '0, 1'b1, "drain_a", t);
    chk("drain_a.data", 32'(m_data), 32'hB);
    cycle(1'b0, '0, 1'b1, "drain_b", t);

    // Simultaneous in and out while BUSY.
    cycle(1'b1, 4'h6, 1'b0, "sim_load", t);
    cycle(1'b1, 4'h7, 1'b1, "sim_swap", t);
    chk("sim_swap.data", 32'(m_data), 32'h7);
    chk("sim_swap.level", 32'(level), 32'd1);
    cycle(1'b0, '0, 1'b1, "sim_drain", t);

    // Reset while FULL.
    cycle(1'b1, 4'h3, 1'b0, "mid_3", t);
    cycle(1'b1, 4'h4, 1'b0, "mid_4", t);
    #1 async_rst_n = 1'b0;
    #1 check_reset("mid_rst");
    q.delete();
    exp_rdy = 1'b0;
    #1 async_rst_n = 1'b1;
    cycle(1'b1, 4'h9, 1'b1, "mid_first", t);
    chk("mid_first.no_take", 32'(t), 32'd0);
    cycle(1'b1, 4'h5, 1'b1, "mid_5", t);
    chk("mid_5.data", 32'(m_data), 32'h5);
    cycle(1'b0, '0, 1'b1, "mid_drain", t);

    // Random traffic with random backpressure.
    sent = 0;
    cyc  = 0;
    while (sent < 1000 && cyc < 20000) begin
      cycle(1'($urandom_range(0, 1)), W'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), "rand", t);
      if (t) sent++;
      cyc++;
    end
    chk("rand.words_sent", 32'(sent), 32'd1000);
    for (int i = 0; i < 3; i++)
      cycle(1'b0, '0, 1'b1, "rand_drain", t);
    chk("rand_drain.empty", 32'(m_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
